seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised Moore sequence detector. Successor to the fixed 4-bit non-overlapping detectors in the FSM library.
- Pattern length and pattern value are set by parameters.
- Overlap or non-overlap mode is selected at runtime by an input.
- Contains a saturating match counter. Sits on a serial bit stream: one bit per enabled clock.

Parameters:
- SEQ_LEN, 4, pattern length in bits, legal range 1..16.
- SEQ, 4'b1101, pattern. SEQ[SEQ_LEN-1] is the first bit received.
- CNT_W, 8, match counter width, minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low: asserts immediately, releases synchronously to clk.
- en  in  1  sample enable. When high, x is consumed this cycle.
- x  in  1  serial input bit.
- mode_ovl  in  1  1 = overlapping detection, 0 = non-overlapping.
- clr  in  1  synchronous clear of match_cnt.
- z  out  1  Moore detect output.
- state_o  out  $clog2(SEQ_LEN+1)  current matched-prefix length, for debug.
- match_cnt  out  CNT_W  number of detections, saturating. Present only with the optional feature.

Behaviour:
- Reset (rst=0): state=0, z=0, match_cnt=0. Reset mid-pattern discards any partial match.
- State k = number of leading pattern bits currently matched, 0..SEQ_LEN. State SEQ_LEN is DETECT.
- z = (state == SEQ_LEN). It is decoded from the state register only, never from x.
- Latency: the last pattern bit is sampled at edge N; z is high for the cycle after edge N.
- z stays high for exactly one cycle per detection while en=1. If en=0, state holds, so z holds.
- en=0: state, z and match_cnt all hold. x is ignored.
- Next state from state k with input x:
  - Let s = first k pattern bits followed by x.
  - next = largest j <= SEQ_LEN such that the last j bits of s equal the first j pattern bits. This is the KMP fallback.
  - Mismatch never blindly returns to 0.
- From DETECT with mode_ovl=1: next state is computed with k=SEQ_LEN (standard rule above).
- From DETECT with mode_ovl=0: next state is computed as if k=0. next = 1 if x == SEQ[SEQ_LEN-1], else 0.
- mode_ovl is only consulted on the transition out of DETECT. Changing it mid-pattern has no other effect.
- SEQ_LEN=1: every matching bit detects. In non-overlap and overlap mode alike, consecutive matching bits give consecutive z pulses.
- Transition table is computed at elaboration by a constant function. No runtime history register.
- match_cnt:
  - +1 on each enabled transition into DETECT, including DETECT->DETECT.
  - Saturates at all-ones.
  - clr has priority over increment: clr=1 with a simultaneous detection gives match_cnt=0.
  - clr acts regardless of en.

Optional Feature:
- Macro: SEQDET_MATCH_CNT_EN.
- Defined: match_cnt port, counter, clr behaviour present as above.
- Undefined: match_cnt port and counter removed. clr is ignored, kept for a fixed pinout. z and state behaviour are identical.

Decomposition:
- Package seqdet_pkg holds:
  - constant function next_state(k, x, SEQ, SEQ_LEN);
  - state width helper function;
  - localparam for the DETECT encoding.
- One sub-module, seqdet_sat_counter (width CNT_W; inc, clr, en), instantiated under SEQDET_MATCH_CNT_EN.
- The FSM stays in the top module.

Test Plan:
- Default params, mode_ovl=0, en=1, stream 01101101011010 (first bit first) -> z high after bits 5 and 13 only; match_cnt=2.
- Same stream, mode_ovl=1 -> z high after bits 5, 8 and 13; after bit 6 state_o=2 (fallback, not 0); match_cnt=3.
- SEQ_LEN=3, SEQ=3'b111, stream 11111:
  - mode_ovl=1 -> z after bits 3, 4, 5.
  - mode_ovl=0 -> z after bit 3 only; state_o=2 at end.
- Default params: feed 110, drop rst for one cycle, then feed 1 -> no detect; state_o=1.
- Feed 11 then 01 with en=0 cycles inserted between every bit, x toggling randomly while en=0 -> z after final enabled bit exactly once; state holds across gaps.
- CNT_W=2, mode_ovl=1, SEQ=1'b1, SEQ_LEN=1, five 1s -> match_cnt=3 (saturated). Then assert clr on a detecting cycle -> match_cnt=0. Without macro: no match_cnt port, z unchanged.

Source files
------------

// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared helpers for seq_detector_param: KMP transition function, state width, DETECT code
package seqdet_pkg;

    localparam int MAX_SEQ_LEN = 16;

    // The DETECT state is encoded as the full pattern length.
    localparam int DETECT_IS_SEQ_LEN = 1;

    function automatic int state_w(input int seq_len);
        return (seq_len < 1) ? 1 : $clog2(seq_len + 1);
    endfunction

    function automatic int detect_code(input int seq_len);
        return DETECT_IS_SEQ_LEN * seq_len;
    endfunction

    // Longest pattern prefix that is a suffix of (first k pattern bits, x).
    function automatic int next_state(input int k, input logic x,
                                      input logic [MAX_SEQ_LEN-1:0] seq, input int seq_len);
        logic [MAX_SEQ_LEN:0] s;
        int best;
        bit ok;
        s = '0;
        best = 0;
        if (k > seq_len || k < 0) return 0;
        for (int i = 0; i < MAX_SEQ_LEN; i++) begin
            if (i < k) s[i] = seq[seq_len-1-i];
        end
        s[k] = x;
        for (int j = 1; j <= MAX_SEQ_LEN; j++) begin
            if (j <= seq_len && j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < MAX_SEQ_LEN; i++) begin
                    if (i < j) begin
                        if (s[k+1-j+i] != seq[seq_len-1-i]) ok = 1'b0;
                    end
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// rtl/seqdet_sat_counter.sv - saturating event counter with synchronous clear that overrides increment
module seqdet_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised Moore sequence detector; match counter under SEQDET_MATCH_CNT_EN
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] SEQ     = 4'b1101,
    parameter int                 CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        x,
    input  logic                        mode_ovl,
    input  logic                        clr,
    output logic                        z,
    output logic [state_w(SEQ_LEN)-1:0] state_o
`ifdef SEQDET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]            match_cnt
`endif
);

    localparam int           SW     = state_w(SEQ_LEN);
    localparam int           NTAB   = 1 << SW;
    localparam logic [SW-1:0] DETECT = SW'(detect_code(SEQ_LEN));

    logic [SW-1:0] tbl0 [NTAB];
    logic [SW-1:0] tbl1 [NTAB];
    logic [SW-1:0] state;
    logic [SW-1:0] state_nxt;
    logic [SW-1:0] k_eff;

    // Transition table resolved at elaboration; unreachable codes fall back to 0.
    for (genvar k = 0; k < NTAB; k++) begin : g_tbl
        localparam int N0 = next_state(k, 1'b0, MAX_SEQ_LEN'(SEQ), SEQ_LEN);
        localparam int N1 = next_state(k, 1'b1, MAX_SEQ_LEN'(SEQ), SEQ_LEN);
        assign tbl0[k] = SW'(N0);
        assign tbl1[k] = SW'(N1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= '0;
        end else begin
            state <= state_nxt;
        end
    end

    // Non-overlap mode restarts from the empty prefix after a detection.
    always_comb begin
        k_eff = state;
        if ((state == DETECT) && !mode_ovl) k_eff = '0;
        state_nxt = state;
        if (en) state_nxt = x ? tbl1[k_eff] : tbl0[k_eff];
    end

    always_comb begin
        z       = (state == DETECT);
        state_o = state;
    end

`ifdef SEQDET_MATCH_CNT_EN
    seqdet_sat_counter #(
        .W   (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .inc (state_nxt == DETECT),
        .clr (clr),
        .cnt (match_cnt)
    );
`else
    logic unused_clr;
    assign unused_clr = clr;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench; counter checks under SEQDET_MATCH_CNT_EN
module tb_seq_detector_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic       a_rst, a_en, a_x, a_mode, a_clr, a_z;
    logic [2:0] a_st;
    logic       b_rst, b_en, b_x, b_mode, b_clr, b_z;
    logic [1:0] b_st;
    logic       c_rst, c_en, c_x, c_mode, c_clr, c_z;
    logic [0:0] c_st;
`ifdef SEQDET_MATCH_CNT_EN
    logic [7:0] a_cnt;
    logic [7:0] b_cnt;
    logic [1:0] c_cnt;
`endif

    seq_detector_param u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .x(a_x), .mode_ovl(a_mode), .clr(a_clr),
        .z(a_z), .state_o(a_st)
`ifdef SEQDET_MATCH_CNT_EN
        , .match_cnt(a_cnt)
`endif
    );

    seq_detector_param #(.SEQ_LEN(3), .SEQ(3'b111), .CNT_W(8)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .x(b_x), .mode_ovl(b_mode), .clr(b_clr),
        .z(b_z), .state_o(b_st)
`ifdef SEQDET_MATCH_CNT_EN
        , .match_cnt(b_cnt)
`endif
    );

    seq_detector_param #(.SEQ_LEN(1), .SEQ(1'b1), .CNT_W(2)) u_c (
        .clk(clk), .rst(c_rst), .en(c_en), .x(c_x), .mode_ovl(c_mode), .clr(c_clr),
        .z(c_z), .state_o(c_st)
`ifdef SEQDET_MATCH_CNT_EN
        , .match_cnt(c_cnt)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        a_rst = 1'b0; a_en = 1'b0; a_x = 1'b0; a_clr = 1'b0;
        tick();
        a_rst = 1'b1;
    endtask

    logic [13:0] strm = 14'b01101101011010;
    int exp_nov [14] = '{0, 1, 2, 3, 4, 1, 0, 1, 0, 1, 2, 3, 4, 0};
    int exp_ovl [14] = '{0, 1, 2, 3, 4, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    int exp_b1  [5]  = '{1, 2, 3, 3, 3};
    int exp_b0  [5]  = '{1, 2, 3, 1, 2};
    logic [3:0] gap_bits = 4'b1101;
    int gap_st  [4]  = '{1, 2, 3, 4};

    initial begin
        {a_rst, a_en, a_x, a_mode, a_clr} = '0;
        {b_rst, b_en, b_x, b_mode, b_clr} = '0;
        {c_rst, c_en, c_x, c_mode, c_clr} = '0;
        tick();
        tick();
        check("rst_a_st", int'(a_st), 0);
        check("rst_a_z", int'(a_z), 0);
        check("rst_b_st", int'(b_st), 0);
        check("rst_c_z", int'(c_z), 0);
`ifdef SEQDET_MATCH_CNT_EN
        check("rst_a_cnt", int'(a_cnt), 0);
        check("rst_c_cnt", int'(c_cnt), 0);
`endif
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;

        a_mode = 1'b0; a_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            a_x = strm[13-i];
            tick();
            check($sformatf("nov_st[%0d]", i + 1), int'(a_st), exp_nov[i]);
            check($sformatf("nov_z[%0d]", i + 1), int'(a_z), int'(exp_nov[i] == 4));
        end
`ifdef SEQDET_MATCH_CNT_EN
        check("nov_cnt", int'(a_cnt), 2);
`endif

        reset_a();
        a_mode = 1'b1; a_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            a_x = strm[13-i];
            tick();
            check($sformatf("ovl_st[%0d]", i + 1), int'(a_st), exp_ovl[i]);
            check($sformatf("ovl_z[%0d]", i + 1), int'(a_z), int'(exp_ovl[i] == 4));
        end
`ifdef SEQDET_MATCH_CNT_EN
        check("ovl_cnt", int'(a_cnt), 3);
`endif

        b_mode = 1'b1; b_en = 1'b1; b_x = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("b_ovl_st[%0d]", i + 1), int'(b_st), exp_b1[i]);
            check($sformatf("b_ovl_z[%0d]", i + 1), int'(b_z), int'(exp_b1[i] == 3));
        end
        b_rst = 1'b0; b_en = 1'b0;
        tick();
        b_rst = 1'b1; b_mode = 1'b0; b_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("b_nov_st[%0d]", i + 1), int'(b_st), exp_b0[i]);
            check($sformatf("b_nov_z[%0d]", i + 1), int'(b_z), int'(exp_b0[i] == 3));
        end
        b_en = 1'b0;

        reset_a();
        a_en = 1'b1;
        a_x = 1'b1; tick();
        a_x = 1'b1; tick();
        a_x = 1'b0; tick();
        check("midrst_pre_st", int'(a_st), 3);
        a_rst = 1'b0;
        #1;
        check("midrst_async_st", int'(a_st), 0);
        tick();
        a_rst = 1'b1;
        a_x = 1'b1; tick();
        check("midrst_st", int'(a_st), 1);
        check("midrst_z", int'(a_z), 0);

        reset_a();
        a_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_en = 1'b1; a_x = gap_bits[3-i];
            tick();
            check($sformatf("gap_st[%0d]", i), int'(a_st), gap_st[i]);
            check($sformatf("gap_z[%0d]", i), int'(a_z), int'(i == 3));
            for (int g = 0; g < 2; g++) begin
                a_en = 1'b0; a_x = 1'($urandom_range(0, 1));
                tick();
                check($sformatf("gap_hold_st[%0d]", i), int'(a_st), gap_st[i]);
                check($sformatf("gap_hold_z[%0d]", i), int'(a_z), int'(i == 3));
            end
        end
`ifdef SEQDET_MATCH_CNT_EN
        check("gap_cnt", int'(a_cnt), 1);
`endif
        a_en = 1'b1; a_x = 1'b0;
        tick();
        check("gap_end_z", int'(a_z), 0);
        a_en = 1'b0;

        c_mode = 1'b1; c_en = 1'b1; c_x = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("c_z[%0d]", i), int'(c_z), 1);
`ifdef SEQDET_MATCH_CNT_EN
            check($sformatf("c_cnt[%0d]", i), int'(c_cnt), (i < 2) ? i + 1 : 3);
`endif
        end
        c_clr = 1'b1;
        tick();
        check("c_clr_z", int'(c_z), 1);
`ifdef SEQDET_MATCH_CNT_EN
        check("c_clr_cnt", int'(c_cnt), 0);
`endif
        c_clr = 1'b0;
        tick();
`ifdef SEQDET_MATCH_CNT_EN
        check("c_after_clr_cnt", int'(c_cnt), 1);
`endif
        c_en = 1'b0; c_clr = 1'b1;
        tick();
        check("c_noen_z", int'(c_z), 1);
`ifdef SEQDET_MATCH_CNT_EN
        check("c_clr_noen_cnt", int'(c_cnt), 0);
`endif
        c_clr = 1'b0; c_mode = 1'b0; c_en = 1'b1; c_x = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("c_nov_z[%0d]", i), int'(c_z), 1);
        end
        c_x = 1'b0;
        tick();
        check("c_zero_z", int'(c_z), 0);
        check("c_zero_st", int'(c_st), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
